// File: rtl/vga_scanout_pkg.sv
// ---------------------------------------------------------------------------
// vga_scanout_pkg
// Shared definitions for the VGA line scan-out stage: default 480p geometry,
// colour widths, write-side FSM encoding and the line-wrap helper.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_scanout_pkg;

    localparam int DEF_H_RES   = 640;
    localparam int H_TOTAL     = 800;
    localparam int DEF_V_RES   = 480;
    localparam int DEF_V_TOTAL = 525;

    localparam int COLOR_W = 4;
    localparam int PIX_W   = 3 * COLOR_W;

    // Write side: FILL accepts pixels into the back bank, DONE holds a
    // complete line until the next swap event.
    typedef enum logic {
        WR_FILL = 1'b0,
        WR_DONE = 1'b1
    } wr_state_t;

    // Index of the line following y, wrapping at the end of the frame.
    function automatic logic [9:0] next_line(input logic [9:0] y, input int v_total);
        return (y == 10'(v_total - 1)) ? 10'd0 : y + 10'd1;
    endfunction

endpackage

// File: rtl/vga_scanout_line_ram.sv
// ---------------------------------------------------------------------------
// line_ram
// Two line buffers (banks) in one simple dual-port RAM, 2*LINE x W.
// Logical address is {bank, x}; bank 1 sits directly above bank 0.
// Ports:
//   clk_pix          pixel clock
//   we, wr_bank,     write enable, bank and pixel index
//   wr_x, wr_data    write pixel index and data
//   re, rd_bank,     read enable, bank and pixel index
//   rd_x
//   rd_data          registered read data (valid the cycle after re)
// ---------------------------------------------------------------------------
module line_ram #(
    parameter int LINE = 640,
    parameter int W    = 12
) (
    input  logic         clk_pix,
    input  logic         we,
    input  logic         wr_bank,
    input  logic [9:0]   wr_x,
    input  logic [W-1:0] wr_data,
    input  logic         re,
    input  logic         rd_bank,
    input  logic [9:0]   rd_x,
    output logic [W-1:0] rd_data
);

    localparam int AW = $clog2(2 * LINE);

    logic [W-1:0]  mem [2*LINE];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_bank ? AW'(LINE) + AW'(wr_x) : AW'(wr_x);
    assign rd_idx = rd_bank ? AW'(LINE) + AW'(rd_x) : AW'(rd_x);

    // NOTE: storage has no reset so it maps onto block RAM; readers gate
    // stale contents with front_valid instead.
    always_ff @(posedge clk_pix) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
// Double-buffered line scan-out. The producer fills line N+1 into the back
// bank over valid/ready while line N is read from the front bank and driven
// to the VGA pins. Banks swap at x==H_RES of the line before the new one.
// Optional build macro SCANOUT_ERR_COLOR_EN: lines that missed their swap
// (after first sync) show magenta instead of black.
// Ports:
//   clk_pix, resetn          pixel clock, synchronous active-low reset
//   x, y, hsync, vsync,      480p timing generator outputs
//   active
//   in_valid, in_rgb,        producer pixel stream {r,g,b}
//   in_ready
//   req_line                 line the producer must deliver next
//   underflow                sticky: a line was not ready at its swap
//   vga_r/g/b, vga_hsync,    registered outputs, timing inputs + 2 cycles
//   vga_vsync
// ---------------------------------------------------------------------------
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic        clk_pix,
    input  logic        resetn,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        active,
    input  logic        in_valid,
    input  logic [11:0] in_rgb,
    output logic        in_ready,
    output logic [8:0]  req_line,
    output logic        underflow,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    // ---------------- write side / bank control ----------------
    wr_state_t  wr_state, wr_state_nx;
    logic [9:0] wr_x, wr_x_nx;
    logic [8:0] req_nx;
    logic       front_bank, front_bank_nx;
    logic       front_valid, front_valid_nx;
    logic       synced, synced_nx;
    logic       underflow_nx;

    logic [9:0] n_line;
    logic       swap_evt, evt_live, accept, last_px, line_ok;

    assign n_line   = next_line(y, V_TOTAL);
    assign swap_evt = (x == 10'(H_RES)) && (n_line < 10'(V_RES));
    // Until the first sync only the event for line 0 counts, so a reset
    // mid-frame simply waits for the next frame without flagging underflow.
    assign evt_live = swap_evt && (synced || (n_line == 10'd0));
    assign in_ready = (wr_state == WR_FILL);
    assign accept   = in_valid && in_ready;
    assign last_px  = accept && (wr_x == 10'(H_RES - 1));
    assign line_ok  = ((wr_state == WR_DONE) || last_px) && ({1'b0, req_line} == n_line);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        wr_state_nx    = wr_state;
        wr_x_nx        = wr_x;
        req_nx         = req_line;
        front_bank_nx  = front_bank;
        front_valid_nx = front_valid;
        synced_nx      = synced;
        underflow_nx   = underflow;

        if (accept) begin
            wr_x_nx = wr_x + 10'd1;
            if (last_px) begin
                wr_state_nx = WR_DONE;
            end
        end

        // A live event restarts the fill whatever happened above; a
        // non-final pixel accepted this cycle is dropped with the partial line.
        if (evt_live) begin
            if (line_ok) begin
                front_bank_nx  = ~front_bank;
                front_valid_nx = 1'b1;
            end else begin
                front_valid_nx = 1'b0;
                if (synced) begin
                    underflow_nx = 1'b1;
                end
            end
            wr_state_nx = WR_FILL;
            wr_x_nx     = 10'd0;
            req_nx      = (n_line == 10'(V_RES - 1)) ? 9'd0 : 9'(n_line + 10'd1);
            synced_nx   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_pix) begin
        if (!resetn) begin
            wr_state    <= WR_FILL;
            wr_x        <= '0;
            req_line    <= '0;
            front_bank  <= 1'b0;
            front_valid <= 1'b0;
            synced      <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wr_state    <= wr_state_nx;
            wr_x        <= wr_x_nx;
            req_line    <= req_nx;
            front_bank  <= front_bank_nx;
            front_valid <= front_valid_nx;
            synced      <= synced_nx;
            underflow   <= underflow_nx;
        end
    end

    // ---------------- line buffers ----------------
    logic [PIX_W-1:0] ram_q;
    logic             rd_en;
    logic             back_bank;

    assign rd_en     = (x < 10'(H_RES));
    assign back_bank = ~front_bank;

    line_ram #(
        .LINE (H_RES),
        .W    (PIX_W)
    ) u_line_ram (
        .clk_pix (clk_pix),
        .we      (accept),
        .wr_bank (back_bank),
        .wr_x    (wr_x),
        .wr_data (in_rgb),
        .re      (rd_en),
        .rd_bank (front_bank),
        .rd_x    (x),
        .rd_data (ram_q)
    );

    // ---------------- output pipeline ----------------
    // Stage 1 aligns timing with the RAM read; stage 2 is the output register.
    logic active_d1, hsync_d1, vsync_d1, front_valid_d1;
`ifdef SCANOUT_ERR_COLOR_EN
    logic synced_d1;
`endif
    logic [PIX_W-1:0] pix_out;

    always_comb begin
        pix_out = '0;
        if (active_d1) begin
            if (front_valid_d1) begin
                pix_out = ram_q;
            end
`ifdef SCANOUT_ERR_COLOR_EN
            else if (synced_d1) begin
                pix_out = 12'hF0F;
            end
`endif
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!resetn) begin
            active_d1      <= 1'b0;
            hsync_d1       <= 1'b0;
            vsync_d1       <= 1'b0;
            front_valid_d1 <= 1'b0;
`ifdef SCANOUT_ERR_COLOR_EN
            synced_d1      <= 1'b0;
`endif
            vga_r          <= '0;
            vga_g          <= '0;
            vga_b          <= '0;
            vga_hsync      <= 1'b0;
            vga_vsync      <= 1'b0;
        end else begin
            active_d1      <= active;
            hsync_d1       <= hsync;
            vsync_d1       <= vsync;
            front_valid_d1 <= front_valid;
`ifdef SCANOUT_ERR_COLOR_EN
            synced_d1      <= synced;
`endif
            vga_r          <= pix_out[11:8];
            vga_g          <= pix_out[7:4];
            vga_b          <= pix_out[3:0];
            vga_hsync      <= hsync_d1;
            vga_vsync      <= vsync_d1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
// Directed bench for vga_scanout. The bench drives the 480p timing itself
// (jumping between lines of interest) and a scripted producer whose pixel
// value for line L, index p is (p + 16*L) truncated to 12 bits.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

    logic        clk_pix = 1'b0;
    logic        resetn;
    logic [9:0]  x, y;
    logic        hsync, vsync, active;
    logic        in_valid;
    logic [11:0] in_rgb;
    logic        in_ready;
    logic [8:0]  req_line;
    logic        underflow;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;

    always #5 clk_pix = ~clk_pix;

    vga_scanout dut (
        .clk_pix   (clk_pix),
        .resetn    (resetn),
        .x         (x),
        .y         (y),
        .hsync     (hsync),
        .vsync     (vsync),
        .active    (active),
        .in_valid  (in_valid),
        .in_rgb    (in_rgb),
        .in_ready  (in_ready),
        .req_line  (req_line),
        .underflow (underflow),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Producer state.
    int p_line  = 0;
    int p_cnt   = 0;
    int p_limit = 640;
    bit p_on    = 1'b0;
    int acc_cnt = 0;
    bit rdy_seen;

    // Coordinates driven one cycle before the current one; the outputs
    // observed after a cycle belong to these.
    int prev_x = -1;
    int prev_y = 0;
    int prev_show = 0;

    function automatic logic [11:0] pat(input int l, input int p);
        return 12'(p + 16 * l);
    endfunction

    // show: 0 black, 1 pattern of line y, 2 missed line, <0 unchecked.
    function automatic logic [11:0] exp_col(input int px, input int py, input int show);
        if (px >= 640 || py >= 480) return 12'h000;
        if (show == 1) return pat(py, px);
`ifdef SCANOUT_ERR_COLOR_EN
        if (show == 2) return 12'hF0F;
`endif
        return 12'h000;
    endfunction

    function automatic bit is_probe(input int px);
        return px == 0 || px == 1 || px == 5 || px == 100 || px == 639 ||
               px == 640 || px == 655 || px == 656 || px == 751 || px == 752;
    endfunction

    task automatic cyc(input int xi, input int yi, input int show);
        bit hs;
        x      = 10'(xi);
        y      = 10'(yi);
        hsync  = !(xi >= 656 && xi < 752);
        vsync  = !(yi >= 490 && yi < 492);
        active = (xi < 640) && (yi < 480);
        in_valid = p_on && (p_cnt < p_limit);
        in_rgb   = pat(p_line, p_cnt);
        @(negedge clk_pix);
        rdy_seen = in_ready;
        hs = in_valid && in_ready;
        @(posedge clk_pix);
        #1;
        if (hs) begin
            p_cnt++;
            acc_cnt++;
        end
        if (prev_x >= 0 && is_probe(prev_x)) begin
            if (prev_show >= 0)
                check($sformatf("rgb y%0d x%0d", prev_y, prev_x),
                      {vga_r, vga_g, vga_b}, exp_col(prev_x, prev_y, prev_show));
            check($sformatf("hsync y%0d x%0d", prev_y, prev_x), vga_hsync,
                  !(prev_x >= 656 && prev_x < 752));
            check($sformatf("vsync y%0d x%0d", prev_y, prev_x), vga_vsync,
                  !(prev_y >= 490 && prev_y < 492));
        end
        prev_x = xi;
        prev_y = yi;
        prev_show = show;
    endtask

    // One full line. At x==640 the producer is retargeted (next_l >= 0);
    // on_x == -2 parks the producer after that, on_x >= 0 starts it at x.
    task automatic run_line(input int yi, input int show, input int next_l, input int lim,
                            input int exp_w, input int on_x, input bit chk_rdy);
        for (int xi = 0; xi < 800; xi++) begin
            if (xi == on_x) p_on = 1'b1;
            cyc(xi, yi, show);
            if (chk_rdy && xi == 639) check($sformatf("in_ready done y%0d", yi), rdy_seen, 0);
            if (chk_rdy && xi == 641) check($sformatf("in_ready fill y%0d", yi), rdy_seen, 1);
            if (xi == 640) begin
                if (exp_w >= 0) check($sformatf("writes y%0d", yi), acc_cnt, exp_w);
                if (next_l >= 0) begin
                    p_line  = next_l;
                    p_cnt   = 0;
                    p_limit = lim;
                    acc_cnt = 0;
                    p_on    = (on_x != -2);
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        p_on   = 1'b0;
        cyc(790, 522, 0);
        cyc(791, 522, 0);
        check("reset rgb", {vga_r, vga_g, vga_b}, 0);
        check("reset hsync", vga_hsync, 0);
        check("reset vsync", vga_vsync, 0);
        check("reset in_ready", in_ready, 1);
        check("reset req_line", req_line, 0);
        check("reset underflow", underflow, 0);
        resetn  = 1'b1;
        prev_x  = -1;
        p_line  = 0;
        p_cnt   = 0;
        p_limit = 640;
        acc_cnt = 0;
        p_on    = 1'b1;

        // Line 0 filled in vertical blanking, swapped in at y=524.
        run_line(523, 0, -1, 640, -1, -1, 0);
        check("in_ready after fill", in_ready, 0);
        run_line(524, 0, 1, 640, 640, -1, 1);
        check("req_line after y524", req_line, 1);
        check("underflow after y524", underflow, 0);
        run_line(0, 1, 2, 640, 640, -1, 1);
        for (int yi = 1; yi <= 4; yi++) run_line(yi, 1, yi + 2, 640, 640, -1, 0);

        // Line 7: final pixel lands in the swap-event cycle itself.
        run_line(5, 1, 7, 640, 640, -2, 0);
        run_line(6, 1, 8, 640, 640, 1, 0);
        check("underflow after late last pixel", underflow, 0);
        check("req_line after y6", req_line, 8);
        run_line(7, 1, 9, 640, 640, -1, 0);

        // Line 10: producer delivers only 100 pixels.
        run_line(8, 1, 10, 100, 640, -1, 0);
        run_line(9, 1, 11, 640, 100, -1, 0);
        check("underflow after short line", underflow, 1);
        check("req_line after short line", req_line, 11);
        run_line(10, 2, 12, 640, 640, -1, 0);
        run_line(11, 1, 13, 640, 640, -1, 0);
        check("underflow sticky", underflow, 1);

        // Reset pulse in the middle of y=200.
        for (int xi = 0; xi < 100; xi++) cyc(xi, 200, -1);
        resetn = 1'b0;
        p_on   = 1'b0;
        cyc(100, 200, 0);
        resetn = 1'b1;
        check("midreset rgb", {vga_r, vga_g, vga_b}, 0);
        check("midreset hsync", vga_hsync, 0);
        check("midreset vsync", vga_vsync, 0);
        check("midreset in_ready", in_ready, 1);
        check("midreset req_line", req_line, 0);
        check("midreset underflow", underflow, 0);
        prev_x  = -1;
        p_line  = 0;
        p_cnt   = 0;
        p_limit = 640;
        acc_cnt = 0;
        p_on    = 1'b1;
        for (int xi = 101; xi < 800; xi++) cyc(xi, 200, 0);
        run_line(201, 0, -1, 640, -1, -1, 0);
        check("no underflow before sync", underflow, 0);
        run_line(490, 0, -1, 640, -1, -1, 0);
        run_line(492, 0, -1, 640, -1, -1, 0);
        run_line(523, 0, -1, 640, -1, -1, 0);
        run_line(524, 0, 1, 640, 640, -1, 1);
        check("underflow after resync", underflow, 0);
        check("req_line after resync", req_line, 1);
        run_line(0, 1, 2, 640, 640, -1, 0);
        check("req_line next frame y0", req_line, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
